// File: rtl/shop_pkg.sv
// Shared types and constants for the vending transaction sequencer:
// state encoding, touch event codes, money_flag encodings and the price table.
package shop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_t;

    localparam logic [4:0] EVT_SEL_MAX = 5'd9;
    localparam logic [4:0] EVT_COIN1   = 5'd16;
    localparam logic [4:0] EVT_COIN5   = 5'd17;
    localparam logic [4:0] EVT_COIN10  = 5'd18;
    localparam logic [4:0] EVT_CONFIRM = 5'd20;
    localparam logic [4:0] EVT_CANCEL  = 5'd21;

    localparam logic [1:0] FLAG_IDLE   = 2'd0;
    localparam logic [1:0] FLAG_ENOUGH = 2'd1;
    localparam logic [1:0] FLAG_SHORT  = 2'd2;
    localparam logic [1:0] FLAG_FULL   = 2'd3;

    localparam logic [3:0] GOODS_NONE = 4'd15;

    localparam logic [6:0] PRICE [0:9] = '{
        7'd5, 7'd8, 7'd10, 7'd15, 7'd20, 7'd25, 7'd30, 7'd40, 7'd50, 7'd60
    };

    // Unselected / out-of-range indices price at 0 so callers need no guard.
    function automatic logic [6:0] price_of(input logic [3:0] idx);
        logic [6:0] p;
        p = 7'd0;
        if (idx <= 4'd9) begin
            p = PRICE[idx];
        end
        return p;
    endfunction

    function automatic logic [6:0] coin_value(input logic [4:0] code);
        logic [6:0] v;
        case (code)
            EVT_COIN1:  v = 7'd1;
            EVT_COIN5:  v = 7'd5;
            EVT_COIN10: v = 7'd10;
            default:    v = 7'd0;
        endcase
        return v;
    endfunction

    function automatic logic is_coin(input logic [4:0] code);
        return (code == EVT_COIN1) || (code == EVT_COIN5) || (code == EVT_COIN10);
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// COLLECT inactivity timer: 1 Hz prescaler plus seconds counter.
// expire pulses for one cycle after TIMEOUT_S*CLK_FREQ uninterrupted run cycles.
module vend_timeout_timer #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TIMEOUT_S = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam int SW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(TIMEOUT_S - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sec_q, sec_d;
    logic          presc_wrap;
    logic          sec_last;

    assign presc_wrap = (presc_q == PRESC_MAX);
    assign sec_last   = (sec_q == SEC_MAX);

    // A clear in the same cycle suppresses expiry: the event wins.
    assign expire = run && !clr && presc_wrap && sec_last;

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (clr || !run) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (presc_wrap) begin
            presc_d = '0;
            sec_d   = sec_last ? '0 : sec_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: credit/selection tracking, dispense and change handshakes.
// Optional inactivity timeout in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vend_txn_ctrl
    import shop_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TIMEOUT_S  = 30,
    parameter int MAX_CREDIT = 99
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       evt_valid,
    input  logic [4:0] evt_code,
    output logic       disp_req,
    input  logic       disp_ack,
    output logic       chg_req,
    output logic [6:0] chg_amount,
    input  logic       chg_ack,
    output logic       coin_reject,
    output logic [6:0] money,
    output logic [3:0] goods_index,
    output logic [1:0] money_flag,
    output logic       busy
);

    // Handshakes: a request rises with the state change that needs it and holds
    // until its ack is sampled high while the request is high; the request falls
    // on that same edge. Acks seen with the request low have no effect.

    localparam logic [6:0] MAX_C = 7'(MAX_CREDIT);

    state_t     state_q, state_d;
    logic [6:0] money_q, money_d;
    logic [3:0] goods_q, goods_d;
    logic [1:0] flag_q, flag_d;
    logic [6:0] chg_amount_q, chg_amount_d;
    logic       disp_req_q, disp_req_d;
    logic       chg_req_q, chg_req_d;
    logic       coin_reject_q, coin_reject_d;
    logic       busy_q, busy_d;

    logic       evt_take;
    logic       tmo_expire;
    logic [7:0] coin_sum;
    logic [6:0] remainder;
    logic [6:0] cur_price;
    logic [6:0] next_price;

    assign evt_take  = evt_valid && !busy_q;
    assign cur_price = price_of(goods_q);

`ifdef VEND_TIMEOUT_EN
    vend_timeout_timer #(
        .CLK_FREQ  (CLK_FREQ),
        .TIMEOUT_S (TIMEOUT_S)
    ) u_timeout (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clr    (evt_take),
        .run    (state_q == ST_COLLECT),
        .expire (tmo_expire)
    );
`else
    // Timer parameters stay in the interface so both builds share one port map.
    assign tmo_expire = 1'b0 & (CLK_FREQ > 0) & (TIMEOUT_S > 0);
`endif

    always_comb begin
        state_d       = state_q;
        money_d       = money_q;
        goods_d       = goods_q;
        chg_amount_d  = chg_amount_q;
        disp_req_d    = disp_req_q;
        chg_req_d     = chg_req_q;
        coin_reject_d = 1'b0;
        coin_sum      = {1'b0, money_q} + {1'b0, coin_value(evt_code)};
        remainder     = money_q - cur_price;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (evt_take) begin
                    if (is_coin(evt_code)) begin
                        if (coin_sum <= {1'b0, MAX_C}) begin
                            money_d = coin_sum[6:0];
                            state_d = ST_COLLECT;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end else if (evt_code <= EVT_SEL_MAX) begin
                        goods_d = evt_code[3:0];
                        state_d = ST_COLLECT;
                    end else if (evt_code == EVT_CONFIRM) begin
                        if (goods_q != GOODS_NONE && money_q >= cur_price) begin
                            state_d    = ST_VEND;
                            disp_req_d = 1'b1;
                        end
                    end else if (evt_code == EVT_CANCEL && state_q == ST_COLLECT) begin
                        if (money_q != 7'd0) begin
                            state_d      = ST_CHANGE;
                            chg_amount_d = money_q;
                            chg_req_d    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            goods_d = GOODS_NONE;
                        end
                    end
                end else if (tmo_expire && state_q == ST_COLLECT) begin
                    if (money_q != 7'd0) begin
                        state_d      = ST_CHANGE;
                        chg_amount_d = money_q;
                        chg_req_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        goods_d = GOODS_NONE;
                    end
                end
            end

            ST_VEND: begin
                if (disp_ack && disp_req_q) begin
                    disp_req_d = 1'b0;
                    money_d    = remainder;
                    if (remainder != 7'd0) begin
                        state_d      = ST_CHANGE;
                        chg_amount_d = remainder;
                        chg_req_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        goods_d = GOODS_NONE;
                    end
                end
            end

            ST_CHANGE: begin
                if (chg_ack && chg_req_q) begin
                    chg_req_d    = 1'b0;
                    chg_amount_d = 7'd0;
                    money_d      = 7'd0;
                    goods_d      = GOODS_NONE;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);

        // Flag reflects the post-edge credit/selection so it tracks money with no lag.
        next_price = price_of(goods_d);
        if (money_d == MAX_C) begin
            flag_d = FLAG_FULL;
        end else if (state_d == ST_COLLECT && goods_d != GOODS_NONE) begin
            flag_d = (money_d >= next_price) ? FLAG_ENOUGH : FLAG_SHORT;
        end else begin
            flag_d = FLAG_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            money_q       <= 7'd0;
            goods_q       <= GOODS_NONE;
            flag_q        <= FLAG_IDLE;
            chg_amount_q  <= 7'd0;
            disp_req_q    <= 1'b0;
            chg_req_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            money_q       <= money_d;
            goods_q       <= goods_d;
            flag_q        <= flag_d;
            chg_amount_q  <= chg_amount_d;
            disp_req_q    <= disp_req_d;
            chg_req_q     <= chg_req_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign disp_req    = disp_req_q;
    assign chg_req     = chg_req_q;
    assign chg_amount  = chg_amount_q;
    assign coin_reject = coin_reject_q;
    assign money       = money_q;
    assign goods_index = goods_q;
    assign money_flag  = flag_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl; with VEND_TIMEOUT_EN defined it also
// exercises the inactivity timeout using a 100-cycle second.
module tb_vend_txn_ctrl;

`ifdef VEND_TIMEOUT_EN
    localparam int TB_CLK_FREQ  = 100;
    localparam int TB_TIMEOUT_S = 1;
`else
    localparam int TB_CLK_FREQ  = 50_000_000;
    localparam int TB_TIMEOUT_S = 30;
`endif

    localparam logic [4:0] C_SEL3   = 5'd3;
    localparam logic [4:0] C_SEL7   = 5'd7;
    localparam logic [4:0] C_COIN1  = 5'd16;
    localparam logic [4:0] C_COIN5  = 5'd17;
    localparam logic [4:0] C_COIN10 = 5'd18;
    localparam logic [4:0] C_CONF   = 5'd20;
    localparam logic [4:0] C_CANCEL = 5'd21;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       evt_valid;
    logic [4:0] evt_code;
    logic       disp_req;
    logic       disp_ack;
    logic       chg_req;
    logic [6:0] chg_amount;
    logic       chg_ack;
    logic       coin_reject;
    logic [6:0] money;
    logic [3:0] goods_index;
    logic [1:0] money_flag;
    logic       busy;

    int n_vec;
    int n_miss;

    vend_txn_ctrl #(
        .CLK_FREQ   (TB_CLK_FREQ),
        .TIMEOUT_S  (TB_TIMEOUT_S),
        .MAX_CREDIT (99)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .disp_req    (disp_req),
        .disp_ack    (disp_ack),
        .chg_req     (chg_req),
        .chg_amount  (chg_amount),
        .chg_ack     (chg_ack),
        .coin_reject (coin_reject),
        .money       (money),
        .goods_index (goods_index),
        .money_flag  (money_flag),
        .busy        (busy)
    );

    // Clock / reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic do_reset();
        sys_rst_n = 1'b0;
        evt_valid = 1'b0;
        evt_code  = 5'd0;
        disp_ack  = 1'b0;
        chg_ack   = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    // Drivers: each returns on the falling edge after the sampling edge.
    task automatic send_evt(input logic [4:0] code);
        @(negedge sys_clk);
        evt_valid = 1'b1;
        evt_code  = code;
        @(negedge sys_clk);
        evt_valid = 1'b0;
        evt_code  = 5'd0;
    endtask

    task automatic send_disp_ack();
        @(negedge sys_clk);
        disp_ack = 1'b1;
        @(negedge sys_clk);
        disp_ack = 1'b0;
    endtask

    task automatic send_chg_ack();
        @(negedge sys_clk);
        chg_ack = 1'b1;
        @(negedge sys_clk);
        chg_ack = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        do_reset();

        // Reset state
        chk("rst_money", money, 0);
        chk("rst_goods", goods_index, 15);
        chk("rst_flag", money_flag, 0);
        chk("rst_chg_amount", chg_amount, 0);
        chk("rst_disp_req", disp_req, 0);
        chk("rst_chg_req", chg_req, 0);
        chk("rst_coin_reject", coin_reject, 0);
        chk("rst_busy", busy, 0);

        // Full purchase with change: 20 credit, item 3 at 15
        send_evt(C_COIN10);
        chk("t1_money10", money, 10);
        send_evt(C_COIN10);
        send_evt(C_SEL3);
        chk("t1_goods", goods_index, 3);
        chk("t1_flag_enough", money_flag, 1);
        send_evt(C_CONF);
        chk("t1_disp_req", disp_req, 1);
        chk("t1_busy_vend", busy, 1);
        chk("t1_chg_req_pre", chg_req, 0);
        repeat (3) @(negedge sys_clk);
        chk("t1_disp_req_hold", disp_req, 1);
        send_disp_ack();
        chk("t1_disp_req_drop", disp_req, 0);
        chk("t1_money_rem", money, 5);
        chk("t1_chg_req", chg_req, 1);
        chk("t1_chg_amount", chg_amount, 5);
        @(negedge sys_clk);
        chk("t1_disp_req_no_reassert", disp_req, 0);
        send_chg_ack();
        chk("t1_chg_req_drop", chg_req, 0);
        chk("t1_busy_idle", busy, 0);
        chk("t1_goods_none", goods_index, 15);
        chk("t1_money_zero", money, 0);
        @(negedge sys_clk);
        chk("t1_chg_req_no_reassert", chg_req, 0);

        // Insufficient credit on confirm, then top up
        send_evt(C_COIN5);
        send_evt(C_SEL3);
        send_evt(C_CONF);
        chk("t2_disp_req", disp_req, 0);
        chk("t2_busy", busy, 0);
        chk("t2_flag_short", money_flag, 2);
        send_evt(C_COIN10);
        chk("t2_money", money, 15);
        chk("t2_flag_enough", money_flag, 1);
        send_evt(C_CANCEL);
        chk("t2_cancel_chg_amount", chg_amount, 15);
        send_chg_ack();
        chk("t2_idle_money", money, 0);

        // Credit ceiling: build 95, reject a 10, fill to 99
        for (int i = 0; i < 9; i++) send_evt(C_COIN10);
        send_evt(C_COIN5);
        chk("t3_money95", money, 95);
        chk("t3_flag_noitem", money_flag, 0);
        send_evt(C_COIN10);
        chk("t3_coin_reject", coin_reject, 1);
        chk("t3_money_kept", money, 95);
        @(negedge sys_clk);
        chk("t3_coin_reject_pulse", coin_reject, 0);
        for (int i = 0; i < 4; i++) send_evt(C_COIN1);
        chk("t3_money99", money, 99);
        chk("t3_flag_full", money_flag, 3);
        send_evt(C_SEL3);
        chk("t3_flag_full_prio", money_flag, 3);
        send_evt(C_COIN1);
        chk("t3_reject_at_max", coin_reject, 1);
        chk("t3_money_max_kept", money, 99);
        send_evt(C_CANCEL);
        chk("t3_chg_amount99", chg_amount, 99);
        send_chg_ack();

        // Cancel with credit, coin ignored while busy
        send_evt(C_COIN5);
        send_evt(C_CANCEL);
        chk("t4_chg_req", chg_req, 1);
        chk("t4_chg_amount", chg_amount, 5);
        chk("t4_busy", busy, 1);
        send_evt(C_COIN10);
        chk("t4_money_ignored", money, 5);
        chk("t4_chg_amount_kept", chg_amount, 5);
        send_disp_ack();
        chk("t4_stray_disp_ack", chg_req, 1);
        send_chg_ack();
        chk("t4_idle", busy, 0);
        chk("t4_money0", money, 0);

        // Exact payment: no change handshake
        send_evt(C_COIN10);
        send_evt(C_COIN5);
        send_evt(C_SEL3);
        send_evt(C_CONF);
        chk("t5_disp_req", disp_req, 1);
        send_disp_ack();
        chk("t5_chg_req", chg_req, 0);
        chk("t5_busy", busy, 0);
        chk("t5_goods_none", goods_index, 15);
        chk("t5_money0", money, 0);
        @(negedge sys_clk);
        chk("t5_chg_req_later", chg_req, 0);
        send_disp_ack();
        chk("t5_stray_disp_req", disp_req, 0);
        chk("t5_stray_busy", busy, 0);
        chk("t5_stray_money", money, 0);

        // Reselect overwrites, cancel with zero credit returns to IDLE
        send_evt(C_SEL3);
        send_evt(C_SEL7);
        chk("t6_reselect", goods_index, 7);
        chk("t6_flag_short", money_flag, 2);
        send_evt(5'd25);
        chk("t6_unknown_code", goods_index, 7);
        send_evt(C_CANCEL);
        chk("t6_cancel_goods", goods_index, 15);
        chk("t6_cancel_no_chg", chg_req, 0);
        chk("t6_cancel_flag", money_flag, 0);

        // Async reset in the middle of VEND
        send_evt(C_COIN10);
        send_evt(C_COIN10);
        send_evt(C_SEL3);
        send_evt(C_CONF);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t7_rst_disp_req", disp_req, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_money", money, 0);
        do_reset();

`ifdef VEND_TIMEOUT_EN
        // Timeout acts as cancel after 100 idle cycles in COLLECT
        send_evt(C_COIN1);
        repeat (99) @(negedge sys_clk);
        chk("t8_before_expire", chg_req, 0);
        @(negedge sys_clk);
        chk("t8_expire_chg_req", chg_req, 1);
        chk("t8_expire_amount", chg_amount, 1);
        send_chg_ack();

        // Event in the expiry cycle wins
        send_evt(C_COIN1);
        repeat (98) @(negedge sys_clk);
        send_evt(C_COIN1);
        chk("t8_race_money", money, 2);
        chk("t8_race_chg_req", chg_req, 0);
        chk("t8_race_busy", busy, 0);
        send_evt(C_CANCEL);
        send_chg_ack();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
